// File: rtl/cordic_pkg.sv
// Shared constants, coordinate types and the CORDIC gain-compensation step.
package cordic_pkg;

   localparam int unsigned WIDTH      = 8;
   localparam int unsigned LATENCY    = 7;
   localparam int unsigned DEPTH      = 4;
   localparam int unsigned GAIN       = 155;
   localparam int unsigned GAIN_SHIFT = 8;
   localparam int unsigned PROD_W     = 16;
   localparam int unsigned ROUND      = 1 << (GAIN_SHIFT - 1);

   typedef logic signed [WIDTH-1:0] coord_t;

   typedef struct packed {
      coord_t x;
      coord_t y;
   } coord_pair_t;

   // Multiply by GAIN/2^GAIN_SHIFT, round half up, keep the low WIDTH bits.
   function automatic coord_t gain_comp(input coord_t v);
      logic signed [PROD_W-1:0] p;
      logic signed [PROD_W-1:0] r;
      p = PROD_W'(v) * $signed(PROD_W'(GAIN));
      r = p + $signed(PROD_W'(ROUND));
      r = r >>> GAIN_SHIFT;
      return r[WIDTH-1:0];
   endfunction

endpackage

// File: rtl/cordic_post_fifo.sv
// Show-ahead FIFO of compensated coordinate pairs; the head is held in a register.
module cordic_post_fifo
   import cordic_pkg::*;
#(
   parameter int unsigned DEPTH = cordic_pkg::DEPTH
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        push,
   input  logic        pop,
   input  coord_pair_t wdata,
   output coord_pair_t rdata,
   output logic        full,
   output logic        empty
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   coord_pair_t            mem [DEPTH];
   logic [PTR_W-1:0]       rd_ptr;
   logic [PTR_W-1:0]       wr_ptr;
   logic [CNT_W-1:0]       count;
   logic                   do_pop;

   assign empty  = (count == '0);
   assign full   = (count == CNT_W'(DEPTH));
   assign do_pop = pop && !empty;

   always_ff @(posedge clock) begin
      if (push) mem[wr_ptr] <= wdata;
   end

   // Head register tracks mem[rd_ptr], bypassing the array when the FIFO runs dry.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         rdata  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
         if (do_pop && count > CNT_W'(1)) begin
            rdata <= mem[rd_ptr + PTR_W'(1)];
         end else if (push && (empty || (do_pop && count == CNT_W'(1)))) begin
            rdata <= wdata;
         end
      end
   end

endmodule

// File: rtl/cordic_post.sv
// CORDIC rotator back end: valid tracking, gain removal and buffered valid/ready output.
module cordic_post
   import cordic_pkg::*;
#(
   parameter int unsigned LATENCY = cordic_pkg::LATENCY,
   parameter int unsigned DEPTH   = cordic_pkg::DEPTH
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   output logic             cordic_enable,
   input  logic [WIDTH-1:0] cordxp,
   input  logic [WIDTH-1:0] cordyp,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_x,
   output logic [WIDTH-1:0] out_y,
   output logic             busy
);

   logic [LATENCY-1:0] vld;
   logic               full;
   logic               empty;
   logic               push;
   logic               pop;
   coord_pair_t        wdata;
   coord_pair_t        rdata;

   // Stall the rotator only when a finished sample has nowhere to go.
   assign cordic_enable = !(vld[LATENCY-1] && full);
   assign push          = cordic_enable && vld[LATENCY-1];
   assign out_valid     = !empty;
   assign pop           = out_valid && out_ready;
   assign busy          = (|vld) || !empty;

   assign wdata.x = gain_comp(coord_t'(cordxp));
   assign wdata.y = gain_comp(coord_t'(cordyp));
   assign out_x   = rdata.x;
   assign out_y   = rdata.y;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         vld <= '0;
      end else if (cordic_enable) begin
         vld <= {vld[LATENCY-2:0], in_valid};
      end
   end

   cordic_post_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .wdata (wdata),
      .rdata (rdata),
      .full  (full),
      .empty (empty)
   );

endmodule
